reg_bank_spill_fill: RTL
========================

REG_BANK_SPILL_FILL -- requirements
Module: reg_bank_spill_fill

Interface
REQ-001 The block SHALL have parameter NUM_REGISTERS_PER_BANK, default 28: number of registers moved per operation.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16: memory address width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low (clock_i, reset_i).
REQ-004 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clock_i  in  1  clock, all logic on posedge.
- reset_i  in  1  synchronous reset, active-low.
- spillReq_i  in  1  start copy of bank to memory.
- fillReq_i  in  1  start copy of memory to bank.
- bank_i  in  6  bank to spill/fill.
- baseAddr_i  in  ADDR_WIDTH  memory address of register 0.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- rfBankSelect_o  out  6  bank select to the register file.
- rfReadEnable_o  out  1  register file read enable.
- rfReadAddr_o  out  5  register file read address.
- rfReadData_i  in  16  register file read data, valid the cycle after rfReadEnable_o.
- rfWriteEnable_o  out  1  register file write enable.
- rfWriteAddr_o  out  5  register file write address.
- rfWriteData_o  out  16  register file write data.
- memReq_o  out  1  memory request, held until memAck_i.
- memWrite_o  out  1  1 = write, 0 = read.
- memAddr_o  out  ADDR_WIDTH  memory address.
- memWriteData_o  out  16  memory write data.
- memAck_i  in  1  memory accept; read data valid in the same cycle.
- memReadData_i  in  16  memory read data.
- checksum_o  out  16  transfer checksum (see Configuration).

Function
REQ-005 The block SHALL implement FSM states IDLE, SPILL_READ, SPILL_LATCH, SPILL_MEM, FILL_MEM, FILL_WRITE and DONE, with a register index idx (0..NUM_REGISTERS_PER_BANK-1).
REQ-006 In IDLE, the block SHALL latch bank_i and baseAddr_i, clear idx, and go to SPILL_READ on spillReq_i, or to FILL_MEM on fillReq_i only; spillReq_i SHALL win when both are high.
REQ-007 The block SHALL ignore requests unless it is in IDLE; busy_o SHALL be 1 in every state except IDLE.
REQ-008 In SPILL_READ, the block SHALL assert rfReadEnable_o for exactly one cycle with rfReadAddr_o=idx, then go to SPILL_LATCH.
REQ-009 In SPILL_LATCH, the block SHALL capture rfReadData_i into memWriteData_o, then go to SPILL_MEM.
REQ-010 In SPILL_MEM, the block SHALL hold memReq_o=1, memWrite_o=1 and memAddr_o=base+idx until memAck_i; address and data SHALL stay stable while waiting.
REQ-011 On memAck_i in SPILL_MEM, the block SHALL go to DONE if idx=NUM_REGISTERS_PER_BANK-1; otherwise it SHALL increment idx and go to SPILL_READ.
REQ-012 In FILL_MEM, the block SHALL hold memReq_o=1, memWrite_o=0 and memAddr_o=base+idx until memAck_i, capture memReadData_i on ack, then go to FILL_WRITE.
REQ-013 In FILL_WRITE, the block SHALL assert rfWriteEnable_o for one cycle with rfWriteAddr_o=idx and rfWriteData_o=captured word, then go to DONE if idx is last, else increment idx and go to FILL_MEM.
REQ-014 In DONE, the block SHALL assert done_o for exactly one cycle and return to IDLE; a request present in DONE SHALL be ignored.
REQ-015 rfBankSelect_o SHALL equal the latched bank throughout the operation.
REQ-016 memAddr_o SHALL be computed as base+idx modulo 2^ADDR_WIDTH, wrapping with no error.
REQ-017 memReq_o SHALL deassert in the cycle after memAck_i; the block SHALL never have more than one request outstanding.
REQ-018 The block SHALL never assert rfReadEnable_o and rfWriteEnable_o in the same cycle.

Reset
REQ-019 When reset_i=0 at a clock edge, the block SHALL go to IDLE, set idx=0, and drive every output to 0, including checksum_o.
REQ-020 A reset during an operation SHALL abort it with no done_o pulse; the next request SHALL restart at idx 0.

Configuration
REQ-021 With macro SPILL_CHECKSUM_EN defined, checksum_o SHALL be cleared at operation start and add each transferred 16-bit word modulo 2^16, and SHALL hold its value after DONE until the next start or reset.
REQ-022 Without SPILL_CHECKSUM_EN, checksum_o SHALL be constant 0 and no checksum logic SHALL be present.

Verification
REQ-023 Spill test: bank 3 regs = 0xA000+i, base 0x0100, ack in the same cycle -> writes to 0x0100..0x011B with data 0xA000..0xA01B, then one done_o pulse.
REQ-024 Fill test: memory[0x0200+i] = 0x5500+i, bank 1 -> register file writes addr 0..27 with data 0x5500..0x551B, rfBankSelect_o=1, then done_o.
REQ-025 Ack delayed 3 cycles -> memReq_o, memAddr_o and memWriteData_o stay stable for 4 cycles; no skipped or duplicated index.
REQ-026 spillReq_i=fillReq_i=1 in IDLE -> spill runs; fillReq_i pulsed while busy -> ignored.
REQ-027 Reset after 5 acked spill words -> all outputs 0 the next cycle, no done_o; new spill starts at base+0.
REQ-028 With SPILL_CHECKSUM_EN, the REQ-023 spill -> checksum_o=0x817A at done_o; without the macro -> checksum_o=0.

Source files
------------

// File: rtl/reg_bank_spill_fill.sv
// reg_bank_spill_fill
//   Copies one register-file bank to memory (spill) or memory back into a
//   bank (fill), one 16-bit word per register, NUM_REGISTERS_PER_BANK words
//   per operation starting at register 0 / baseAddr_i.
//
// Optional feature: define SPILL_CHECKSUM_EN to build a running 16-bit sum
//   of every transferred word on checksum_o. Without it checksum_o is 0.
//
// Ports
//   clock_i, reset_i        clock (posedge), synchronous active-low reset
//   spillReq_i, fillReq_i   start requests, sampled only when idle
//   bank_i, baseAddr_i      bank and memory base, latched at start
//   busy_o, done_o          operation active / one-cycle completion pulse
//   rf*                     register-file read/write port and bank select
//   mem*                    single-outstanding memory request port
//   checksum_o              transfer checksum (see SPILL_CHECKSUM_EN)

module reg_bank_spill_fill #(
  parameter int unsigned NUM_REGISTERS_PER_BANK = 28,
  parameter int unsigned ADDR_WIDTH             = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  spillReq_i,
  input  logic                  fillReq_i,
  input  logic [5:0]            bank_i,
  input  logic [ADDR_WIDTH-1:0] baseAddr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [5:0]            rfBankSelect_o,
  output logic                  rfReadEnable_o,
  output logic [4:0]            rfReadAddr_o,
  input  logic [15:0]           rfReadData_i,
  output logic                  rfWriteEnable_o,
  output logic [4:0]            rfWriteAddr_o,
  output logic [15:0]           rfWriteData_o,
  output logic                  memReq_o,
  output logic                  memWrite_o,
  output logic [ADDR_WIDTH-1:0] memAddr_o,
  output logic [15:0]           memWriteData_o,
  input  logic                  memAck_i,
  input  logic [15:0]           memReadData_i,
  output logic [15:0]           checksum_o
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] SPILL_READ  = 3'd1;
  localparam logic [2:0] SPILL_LATCH = 3'd2;
  localparam logic [2:0] SPILL_MEM   = 3'd3;
  localparam logic [2:0] FILL_MEM    = 3'd4;
  localparam logic [2:0] FILL_WRITE  = 3'd5;
  localparam logic [2:0] DONE        = 3'd6;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGISTERS_PER_BANK - 1);

  logic [2:0]            state_q;
  logic [4:0]            idx_q;
  logic [5:0]            bank_q;
  logic [ADDR_WIDTH-1:0] base_q;
  // Single data holding register: spill word from the register file, or
  // fill word from memory. Only one direction is ever active at a time.
  logic [15:0]           data_q;

  logic start;
  assign start = (state_q == IDLE) && (spillReq_i || fillReq_i);

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bank_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (spillReq_i) begin
            state_q <= SPILL_READ;
            bank_q  <= bank_i;
            base_q  <= baseAddr_i;
            idx_q   <= '0;
          end else if (fillReq_i) begin
            state_q <= FILL_MEM;
            bank_q  <= bank_i;
            base_q  <= baseAddr_i;
            idx_q   <= '0;
          end
        end
        SPILL_READ: state_q <= SPILL_LATCH;
        SPILL_LATCH: begin
          data_q  <= rfReadData_i;
          state_q <= SPILL_MEM;
        end
        SPILL_MEM: begin
          if (memAck_i) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= SPILL_READ;
            end
          end
        end
        FILL_MEM: begin
          if (memAck_i) begin
            data_q  <= memReadData_i;
            state_q <= FILL_WRITE;
          end
        end
        FILL_WRITE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 5'd1;
            state_q <= FILL_MEM;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from state and registers, so reset forces all
  // of them to zero on the same edge.
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign rfBankSelect_o  = bank_q;
  assign rfReadEnable_o  = (state_q == SPILL_READ);
  assign rfReadAddr_o    = idx_q;
  assign rfWriteEnable_o = (state_q == FILL_WRITE);
  assign rfWriteAddr_o   = idx_q;
  assign rfWriteData_o   = data_q;
  assign memReq_o        = (state_q == SPILL_MEM) || (state_q == FILL_MEM);
  assign memWrite_o      = (state_q == SPILL_MEM);
  assign memAddr_o       = base_q + ADDR_WIDTH'(idx_q);
  assign memWriteData_o  = data_q;

`ifdef SPILL_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Accumulate on the acknowledged memory beat: that is the moment a word
  // is actually transferred in either direction.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      checksum_q <= '0;
    end else if (start) begin
      checksum_q <= '0;
    end else if ((state_q == SPILL_MEM) && memAck_i) begin
      checksum_q <= checksum_q + data_q;
    end else if ((state_q == FILL_MEM) && memAck_i) begin
      checksum_q <= checksum_q + memReadData_i;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

endmodule
